comp_div: RTL and testbench

Sequential complex divider, the inverse of `comp_mul`. It accepts two signed 8-bit complex operands `a` and `b` and returns the truncated complex quotient a/b = ((a_r·b_r + a_i·b_i) + j(a_i·b_r − a_r·b_i)) / (b_r² + b_i²). It sits on the same operand bus as `comp_mul`, with matching operand widths and 17-bit result widths. A single shared restoring divider computes the real part and then the imaginary part.

---
 rtl/comp_div.sv | 235 +++++++++++++++++++++++
 tb/tb_comp_div.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/comp_div.sv
// comp_div: sequential complex divider, q = a / b for signed 8-bit complex operands.
// The numerators a_r*b_r + a_i*b_i and a_i*b_r - a_r*b_i are formed once, together
// with the denominator b_r^2 + b_i^2. One restoring divider is then used twice:
// first for the real part, then for the imaginary part. Both quotients truncate
// toward zero.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   a_r/a_i  dividend real/imag (signed 8-bit)
//   b_r/b_i  divisor real/imag (signed 8-bit)
//   i_en     start request, sampled only while idle
//   o_r/o_i  quotient real/imag (signed 17-bit), held until the next result
//   o_valid  one-cycle result strobe
//   o_busy   high while an operation is in flight
//   o_dz     divide-by-zero flag, held with the results
module comp_div (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [7:0]  a_r,
  input  logic signed [7:0]  a_i,
  input  logic signed [7:0]  b_r,
  input  logic signed [7:0]  b_i,
  input  logic               i_en,
  output logic signed [16:0] o_r,
  output logic signed [16:0] o_i,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_dz
);

  localparam int unsigned OpW  = 8;
  localparam int unsigned ResW = 17;
  localparam int unsigned RemW = 16;
  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] LastBit = CntW'(ResW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV_R,
    S_DIV_I,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic signed [OpW-1:0]   ar_q, ai_q, br_q, bi_q;
  logic signed [OpW-1:0]   ar_d, ai_d, br_d, bi_d;
  logic [ResW-1:0]         den_q, den_d;
  logic [ResW-1:0]         dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
  logic [RemW-1:0]         rem_q, rem_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    neg_r_q, neg_r_d;
  logic                    neg_i_q, neg_i_d;
  logic [ResW-1:0]         mag_i_q, mag_i_d;
  logic                    dz_q, dz_d;
  logic signed [ResW-1:0]  res_r_q, res_r_d;
  logic signed [ResW-1:0]  res_i_q, res_i_d;
  logic signed [ResW-1:0]  o_r_q, o_r_d;
  logic signed [ResW-1:0]  o_i_q, o_i_d;
  logic                    o_valid_q, o_valid_d;
  logic                    o_busy_q, o_busy_d;
  logic                    o_dz_q, o_dz_d;

  // Sign-extended operands and the products needed in PREP.
  logic signed [ResW-1:0]  ar_x, ai_x, br_x, bi_x;
  logic signed [ResW-1:0]  num_r_c, num_i_c, den_s_c;
  logic [ResW-1:0]         mag_r_c, mag_in_c;

  always_comb begin
    ar_x     = {{(ResW-OpW){ar_q[OpW-1]}}, ar_q};
    ai_x     = {{(ResW-OpW){ai_q[OpW-1]}}, ai_q};
    br_x     = {{(ResW-OpW){br_q[OpW-1]}}, br_q};
    bi_x     = {{(ResW-OpW){bi_q[OpW-1]}}, bi_q};
    // |products| <= 16384, so all sums fit 17-bit signed without overflow.
    num_r_c  = ar_x * br_x + ai_x * bi_x;
    num_i_c  = ai_x * br_x - ar_x * bi_x;
    den_s_c  = br_x * br_x + bi_x * bi_x;
    mag_r_c  = num_r_c[ResW-1] ? ResW'(-num_r_c) : ResW'(num_r_c);
    mag_in_c = num_i_c[ResW-1] ? ResW'(-num_i_c) : ResW'(num_i_c);
  end

  // One restoring-division step. rem < den <= 32768, so the shifted trial fits 17 bits.
  logic [ResW-1:0] trial_c;
  logic            ge_c;
  logic [RemW-1:0] rem_step_c;
  logic [ResW-1:0] q_step_c;

  always_comb begin
    trial_c    = {rem_q, dvd_q[ResW-1]};
    ge_c       = (trial_c >= den_q);
    rem_step_c = ge_c ? RemW'(trial_c - den_q) : trial_c[RemW-1:0];
    q_step_c   = {dvd_q[ResW-2:0], ge_c};
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ar_q      <= '0;
      ai_q      <= '0;
      br_q      <= '0;
      bi_q      <= '0;
      den_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_r_q   <= 1'b0;
      neg_i_q   <= 1'b0;
      mag_i_q   <= '0;
      dz_q      <= 1'b0;
      res_r_q   <= '0;
      res_i_q   <= '0;
      o_r_q     <= '0;
      o_i_q     <= '0;
      o_valid_q <= 1'b0;
      o_busy_q  <= 1'b0;
      o_dz_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_q      <= ar_d;
      ai_q      <= ai_d;
      br_q      <= br_d;
      bi_q      <= bi_d;
      den_q     <= den_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_r_q   <= neg_r_d;
      neg_i_q   <= neg_i_d;
      mag_i_q   <= mag_i_d;
      dz_q      <= dz_d;
      res_r_q   <= res_r_d;
      res_i_q   <= res_i_d;
      o_r_q     <= o_r_d;
      o_i_q     <= o_i_d;
      o_valid_q <= o_valid_d;
      o_busy_q  <= o_busy_d;
      o_dz_q    <= o_dz_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    ar_d      = ar_q;
    ai_d      = ai_q;
    br_d      = br_q;
    bi_d      = bi_q;
    den_d     = den_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_r_d   = neg_r_q;
    neg_i_d   = neg_i_q;
    mag_i_d   = mag_i_q;
    dz_d      = dz_q;
    res_r_d   = res_r_q;
    res_i_d   = res_i_q;
    o_r_d     = o_r_q;
    o_i_d     = o_i_q;
    o_valid_d = 1'b0;
    o_busy_d  = o_busy_q;
    o_dz_d    = o_dz_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_en) begin
          ar_d     = a_r;
          ai_d     = a_i;
          br_d     = b_r;
          bi_d     = b_i;
          o_busy_d = 1'b1;
          state_d  = S_PREP;
        end
      end

      S_PREP: begin
        den_d   = ResW'(den_s_c);
        neg_r_d = num_r_c[ResW-1];
        neg_i_d = num_i_c[ResW-1];
        dvd_d   = mag_r_c;
        mag_i_d = mag_in_c;
        rem_d   = '0;
        cnt_d   = '0;
        res_r_d = '0;
        res_i_d = '0;
        dz_d    = (den_s_c == '0);
        state_d = (den_s_c == '0) ? S_DONE : S_DIV_R;
      end

      S_DIV_R: begin
        rem_d = rem_step_c;
        dvd_d = q_step_c;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          // Real quotient complete: save it and restart the divider on |num_i|.
          res_r_d = neg_r_q ? ResW'(-q_step_c) : ResW'(q_step_c);
          dvd_d   = mag_i_q;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV_I;
        end
      end

      S_DIV_I: begin
        rem_d = rem_step_c;
        dvd_d = q_step_c;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          res_i_d = neg_i_q ? ResW'(-q_step_c) : ResW'(q_step_c);
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        o_r_d     = dz_q ? '0 : res_r_q;
        o_i_d     = dz_q ? '0 : res_i_q;
        o_dz_d    = dz_q;
        o_valid_d = 1'b1;
        o_busy_d  = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign o_r     = o_r_q;
  assign o_i     = o_i_q;
  assign o_valid = o_valid_q;
  assign o_busy  = o_busy_q;
  assign o_dz    = o_dz_q;

endmodule

// File: tb/tb_comp_div.sv
// Self-checking bench for comp_div: directed cases with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_comp_div;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [7:0]  a_r = '0, a_i = '0, b_r = '0, b_i = '0;
  logic               i_en = 1'b0;
  logic signed [16:0] o_r, o_i;
  logic               o_valid, o_busy, o_dz;

  comp_div dut (
    .clk     (clk),
    .rst     (rst),
    .a_r     (a_r),
    .a_i     (a_i),
    .b_r     (b_r),
    .b_i     (b_i),
    .i_en    (i_en),
    .o_r     (o_r),
    .o_i     (o_i),
    .o_valid (o_valid),
    .o_busy  (o_busy),
    .o_dz    (o_dz)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: a/b from plain integer arithmetic ('/' truncates toward zero);
  // the result appears 36 edges after acceptance, or 2 edges when b = 0.
  logic m_valid = 1'b0, m_busy = 1'b0, m_dz = 1'b0;
  int   m_r = 0, m_i = 0, m_cnt = 0;
  int   p_r = 0, p_i = 0, p_dz = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid = 1'b0; m_busy = 1'b0; m_dz = 1'b0;
      m_r = 0; m_i = 0; m_cnt = 0;
    end else begin
      int nr, ni, den;
      m_valid = 1'b0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_valid = 1'b1;
          m_busy  = 1'b0;
          m_r     = p_r;
          m_i     = p_i;
          m_dz    = (p_dz != 0);
        end
      end else if (i_en) begin
        nr  = int'(a_r) * int'(b_r) + int'(a_i) * int'(b_i);
        ni  = int'(a_i) * int'(b_r) - int'(a_r) * int'(b_i);
        den = int'(b_r) * int'(b_r) + int'(b_i) * int'(b_i);
        if (den == 0) begin
          p_r = 0; p_i = 0; p_dz = 1; m_cnt = 2;
        end else begin
          p_r = nr / den; p_i = ni / den; p_dz = 0; m_cnt = 36;
        end
        m_busy = 1'b1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("cyc_valid", int'(o_valid), int'(m_valid));
    chk("cyc_busy",  int'(o_busy),  int'(m_busy));
    chk("cyc_r",     int'(o_r),     m_r);
    chk("cyc_i",     int'(o_i),     m_i);
    chk("cyc_dz",    int'(o_dz),    int'(m_dz));
  end

  // Start one operation from idle and check it against literal expectations.
  task automatic run_op(input logic signed [7:0] ar, input logic signed [7:0] ai,
                        input logic signed [7:0] br, input logic signed [7:0] bi,
                        input int er, input int ei, input int edz, input int elat,
                        input string tag);
    int lat;
    @(negedge clk);
    a_r = ar; a_i = ai; b_r = br; b_i = bi; i_en = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_after_accept"}, int'(o_busy), 1);
    @(negedge clk);
    i_en = 1'b0;
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_r"},  int'(o_r),  er);
    chk({tag, "_i"},  int'(o_i),  ei);
    chk({tag, "_dz"}, int'(o_dz), edz);
    chk({tag, "_busy_at_valid"}, int'(o_busy), 0);
  endtask

  task automatic wait_valid(input string tag, output int at_cyc);
    at_cyc = -1;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (o_valid) begin
        at_cyc = cyc;
        break;
      end
    end
    chk({tag, "_seen"}, int'(at_cyc >= 0), 1);
  endtask

  initial begin
    int c1, c2;
    // Reset state.
    #1;
    chk("reset_r", int'(o_r), 0);
    chk("reset_i", int'(o_i), 0);
    chk("reset_valid_busy_dz", int'({o_valid, o_busy, o_dz}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_op(8'sd10, 8'sd2, 8'sd5, 8'sd1, 2, 0, 0, 36, "basic");
    run_op(-8'sd7, 8'sd3, 8'sd2, -8'sd1, -3, 0, 0, 36, "trunc_neg");
    run_op(8'sd7, -8'sd3, 8'sd2, -8'sd1, 3, 0, 0, 36, "trunc_pos");
    run_op(-8'sd128, -8'sd128, 8'sd1, 8'sd0, -128, -128, 0, 36, "ext_b1");
    run_op(-8'sd128, -8'sd128, -8'sd128, -8'sd128, 1, 0, 0, 36, "ext_same");
    run_op(-8'sd128, -8'sd128, -8'sd1, 8'sd0, 128, 128, 0, 36, "ext_bm1");
    run_op(8'sd5, 8'sd5, 8'sd0, 8'sd0, 0, 0, 1, 2, "dz");
    run_op(8'sd10, 8'sd2, 8'sd5, 8'sd1, 2, 0, 0, 36, "dz_clear");

    // Request during busy is ignored.
    @(negedge clk);
    a_r = 8'sd7; a_i = -8'sd3; b_r = 8'sd2; b_i = -8'sd1; i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    repeat (9) @(negedge clk);
    a_r = -8'sd128; a_i = -8'sd128; b_r = 8'sd1; b_i = 8'sd0; i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    wait_valid("ignore", c1);
    chk("ignore_r", int'(o_r), 3);
    chk("ignore_i", int'(o_i), 0);

    // Back-to-back with i_en held high: results every 37 cycles.
    @(negedge clk);
    a_r = 8'sd10; a_i = 8'sd2; b_r = 8'sd5; b_i = 8'sd1; i_en = 1'b1;
    wait_valid("b2b_first", c1);
    wait_valid("b2b_second", c2);
    @(negedge clk);
    i_en = 1'b0;
    chk("b2b_period", c2 - c1, 37);
    chk("b2b_r", int'(o_r), 2);

    // Reset mid-operation clears everything at once.
    @(negedge clk);
    a_r = -8'sd7; a_i = 8'sd3; b_r = 8'sd2; b_i = -8'sd1; i_en = 1'b1;
    @(negedge clk);
    i_en = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_r", int'(o_r), 0);
    chk("midrst_i", int'(o_i), 0);
    chk("midrst_valid_busy_dz", int'({o_valid, o_busy, o_dz}), 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(8'sd10, 8'sd2, 8'sd5, 8'sd1, 2, 0, 0, 36, "after_rst");

    // Randomized traffic, checked by the model every cycle.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      a_r = 8'($urandom);
      a_i = 8'($urandom);
      b_r = 8'($urandom);
      b_i = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b_r = 8'sd0;
        b_i = 8'sd0;
      end
      if ($urandom_range(0, 9) == 0) a_r = -8'sd128;
      if ($urandom_range(0, 9) == 0) b_i = -8'sd128;
      i_en = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    i_en = 1'b0;
    for (int n = 0; n < 60 && o_busy; n++) @(negedge clk);
    chk("drain_idle", int'(o_busy), 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
